// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if: raster position, display enable and sync outputs shared with the renderers
interface vga_timing_gen_if;
   logic [9:0] DrawX;
   logic [9:0] DrawY;
   logic       blank;
   logic       hs;
   logic       vs;
   logic       line_start;
   logic       frame_start;
   logic [7:0] frame_count;
   modport master (output DrawX, DrawY, blank, hs, vs, line_start, frame_start, frame_count);
   modport slave  (input  DrawX, DrawY, blank, hs, vs, line_start, frame_start, frame_count);
endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: free-running raster counters, display enable and delayed active-low syncs
module vga_timing_gen #(
   parameter int H_VISIBLE  = 640,
   parameter int H_FRONT    = 16,
   parameter int H_SYNC     = 96,
   parameter int H_BACK     = 48,
   parameter int V_VISIBLE  = 480,
   parameter int V_FRONT    = 10,
   parameter int V_SYNC     = 2,
   parameter int V_BACK     = 33,
   parameter int SYNC_DELAY = 1
) (
   input  logic             vga_clk,
   input  logic             reset_n,
   vga_timing_gen_if.master vif
);
   localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
   if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
      $error("vga_timing_gen: H_TOTAL=%0d V_TOTAL=%0d must not exceed 1024", H_TOTAL, V_TOTAL);
   end
   if (SYNC_DELAY < 0 || SYNC_DELAY > 4) begin : g_bad_delay
      $error("vga_timing_gen: SYNC_DELAY=%0d outside 0..4", SYNC_DELAY);
   end
   logic       run_q, run_d;
   logic [9:0] hc_q, hc_d, vc_q, vc_d;
   logic [7:0] fc_q, fc_d;
   logic       h_end, v_end, hs_raw, vs_raw;
   // run_q holds the counters at (0,0) through the first edge after reset release
   always_comb begin
      h_end  = hc_q == 10'(H_TOTAL - 1);
      v_end  = vc_q == 10'(V_TOTAL - 1);
      run_d  = 1'b1;
      hc_d   = !run_q ? hc_q : h_end ? '0 : hc_q + 10'd1;
      vc_d   = !(run_q && h_end) ? vc_q : v_end ? '0 : vc_q + 10'd1;
      fc_d   = run_q && h_end && v_end ? fc_q + 8'd1 : fc_q;
      hs_raw = !(int'(hc_q) >= H_VISIBLE + H_FRONT && int'(hc_q) < H_VISIBLE + H_FRONT + H_SYNC);
      vs_raw = !(int'(vc_q) >= V_VISIBLE + V_FRONT && int'(vc_q) < V_VISIBLE + V_FRONT + V_SYNC);
   end
   always_ff @(posedge vga_clk or negedge reset_n)
      if (!reset_n) begin
         run_q <= 1'b0;
         hc_q  <= '0;
         vc_q  <= '0;
         fc_q  <= '0;
      end else begin
         run_q <= run_d;
         hc_q  <= hc_d;
         vc_q  <= vc_d;
         fc_q  <= fc_d;
      end
   assign vif.DrawX       = hc_q;
   assign vif.DrawY       = vc_q;
   assign vif.frame_count = fc_q;
   assign vif.blank       = reset_n && int'(hc_q) < H_VISIBLE && int'(vc_q) < V_VISIBLE;
   assign vif.line_start  = reset_n && hc_q == '0;
   assign vif.frame_start = reset_n && hc_q == '0 && vc_q == '0;
   // syncs are delayed to line up with the renderers' registered RGB
   if (SYNC_DELAY == 0) begin : g_no_delay
      assign vif.hs = hs_raw;
      assign vif.vs = vs_raw;
   end else begin : g_delay
      logic [SYNC_DELAY-1:0] hs_q, hs_d, vs_q, vs_d;
      always_comb begin
         hs_d = SYNC_DELAY'({hs_q, hs_raw});
         vs_d = SYNC_DELAY'({vs_q, vs_raw});
      end
      always_ff @(posedge vga_clk or negedge reset_n)
         if (!reset_n) begin
            hs_q <= '1;
            vs_q <= '1;
         end else begin
            hs_q <= hs_d;
            vs_q <= vs_d;
         end
      assign vif.hs = hs_q[SYNC_DELAY-1];
      assign vif.vs = vs_q[SYNC_DELAY-1];
   end
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: vector table plus a time-indexed raster model checked every cycle on three configurations
module tb_vga_timing_gen;
   typedef struct packed {
      logic [9:0] x;
      logic [9:0] y;
      logic       blank, hs, vs, ls, fs;
      logic [7:0] fc;
   } obs_t;
   typedef struct {
      int   m;
      int   sel;
      obs_t e;
   } vec_t;
   logic vga_clk = 1'b0;
   logic reset_n = 1'b0;
   int   m = 0;
   int   vectors = 0;
   int   miscompares = 0;
   obs_t a1, a0, ad;
   vec_t tbl[24];
   always #5 vga_clk = ~vga_clk;
   vga_timing_gen_if s1 ();
   vga_timing_gen_if s0 ();
   vga_timing_gen_if sd ();
   vga_timing_gen #(.H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2), .V_VISIBLE(6), .V_FRONT(1),
      .V_SYNC(2), .V_BACK(1), .SYNC_DELAY(1)) u1 (.vga_clk(vga_clk), .reset_n(reset_n), .vif(s1));
   vga_timing_gen #(.H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2), .V_VISIBLE(6), .V_FRONT(1),
      .V_SYNC(2), .V_BACK(1), .SYNC_DELAY(0)) u0 (.vga_clk(vga_clk), .reset_n(reset_n), .vif(s0));
   vga_timing_gen ud (.vga_clk(vga_clk), .reset_n(reset_n), .vif(sd));
   assign a1 = {s1.DrawX, s1.DrawY, s1.blank, s1.hs, s1.vs, s1.line_start, s1.frame_start, s1.frame_count};
   assign a0 = {s0.DrawX, s0.DrawY, s0.blank, s0.hs, s0.vs, s0.line_start, s0.frame_start, s0.frame_count};
   assign ad = {sd.DrawX, sd.DrawY, sd.blank, sd.hs, sd.vs, sd.line_start, sd.frame_start, sd.frame_count};
   // m = rising edges since reset release; edge m shows scan position m-1
   always @(posedge vga_clk or negedge reset_n)
      if (!reset_n) m <= 0;
      else m <= m + 1;
   function automatic obs_t mk(int x, int y, logic b, logic h, logic v, logic l, logic f, int fc);
      obs_t o;
      o.x = 10'(x); o.y = 10'(y); o.blank = b; o.hs = h; o.vs = v; o.ls = l; o.fs = f; o.fc = 8'(fc);
      return o;
   endfunction
   function automatic obs_t model(int mm, logic rn, int hv, int hf, int hsy, int hb,
                                  int vv, int vf, int vsy, int vb, int d);
      int ht, vt, p, q, px, py, qx, qy;
      obs_t o;
      ht = hv + hf + hsy + hb;
      vt = vv + vf + vsy + vb;
      p  = mm == 0 ? 0 : mm - 1;
      q  = mm - 1 - d;
      px = p % ht; py = (p / ht) % vt;
      qx = q < 0 ? 0 : q % ht; qy = q < 0 ? 0 : (q / ht) % vt;
      o.x     = 10'(px);
      o.y     = 10'(py);
      o.fc    = 8'((p / (ht * vt)) % 256);
      o.blank = rn && px < hv && py < vv;
      o.ls    = rn && px == 0;
      o.fs    = rn && px == 0 && py == 0;
      o.hs    = q < 0 || !(qx >= hv + hf && qx < hv + hf + hsy);
      o.vs    = q < 0 || !(qy >= vv + vf && qy < vv + vf + vsy);
      return o;
   endfunction
   function automatic void cmp(string name, obs_t act, obs_t exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s t=%0t m=%0d: got x=%0d y=%0d blank=%b hs=%b vs=%b ls=%b fs=%b fc=%0d, expected x=%0d y=%0d blank=%b hs=%b vs=%b ls=%b fs=%b fc=%0d",
            name, $time, m, act.x, act.y, act.blank, act.hs, act.vs, act.ls, act.fs, act.fc,
            exp.x, exp.y, exp.blank, exp.hs, exp.vs, exp.ls, exp.fs, exp.fc);
      end
   endfunction
   always @(negedge vga_clk) begin
      cmp("model_small_d1", a1, model(m, reset_n, 8, 2, 3, 2, 6, 1, 2, 1, 1));
      cmp("model_small_d0", a0, model(m, reset_n, 8, 2, 3, 2, 6, 1, 2, 1, 0));
      cmp("model_default", ad, model(m, reset_n, 640, 16, 96, 48, 480, 10, 2, 33, 1));
   end
   initial begin
      #1_000_000;
      $display("FAIL watchdog: time limit reached at m=%0d", m);
      $fatal(1, "watchdog");
   end
   initial begin
      tbl[0]  = '{1,     0, mk(0,   0, 1, 1, 1, 1, 1, 0)};
      tbl[1]  = '{2,     0, mk(1,   0, 1, 1, 1, 0, 0, 0)};
      tbl[2]  = '{9,     0, mk(8,   0, 0, 1, 1, 0, 0, 0)};
      tbl[3]  = '{11,    0, mk(10,  0, 0, 1, 1, 0, 0, 0)};
      tbl[4]  = '{11,    1, mk(10,  0, 0, 0, 1, 0, 0, 0)};
      tbl[5]  = '{12,    0, mk(11,  0, 0, 0, 1, 0, 0, 0)};
      tbl[6]  = '{13,    1, mk(12,  0, 0, 0, 1, 0, 0, 0)};
      tbl[7]  = '{14,    0, mk(13,  0, 0, 0, 1, 0, 0, 0)};
      tbl[8]  = '{14,    1, mk(13,  0, 0, 1, 1, 0, 0, 0)};
      tbl[9]  = '{15,    0, mk(14,  0, 0, 1, 1, 0, 0, 0)};
      tbl[10] = '{16,    0, mk(0,   1, 1, 1, 1, 1, 0, 0)};
      tbl[11] = '{106,   0, mk(0,   7, 0, 1, 1, 1, 0, 0)};
      tbl[12] = '{107,   0, mk(1,   7, 0, 1, 0, 0, 0, 0)};
      tbl[13] = '{136,   0, mk(0,   9, 0, 1, 0, 1, 0, 0)};
      tbl[14] = '{137,   0, mk(1,   9, 0, 1, 1, 0, 0, 0)};
      tbl[15] = '{150,   0, mk(14,  9, 0, 1, 1, 0, 0, 0)};
      tbl[16] = '{151,   0, mk(0,   0, 1, 1, 1, 1, 1, 1)};
      tbl[17] = '{657,   2, mk(656, 0, 0, 1, 1, 0, 0, 0)};
      tbl[18] = '{658,   2, mk(657, 0, 0, 0, 1, 0, 0, 0)};
      tbl[19] = '{753,   2, mk(752, 0, 0, 0, 1, 0, 0, 0)};
      tbl[20] = '{754,   2, mk(753, 0, 0, 1, 1, 0, 0, 0)};
      tbl[21] = '{801,   2, mk(0,   1, 1, 1, 1, 1, 0, 0)};
      tbl[22] = '{38400, 0, mk(14,  9, 0, 1, 1, 0, 0, 255)};
      tbl[23] = '{38401, 0, mk(0,   0, 1, 1, 1, 1, 1, 0)};
      repeat (3) @(posedge vga_clk);
      #1;
      cmp("in_reset_small", a1, mk(0, 0, 0, 1, 1, 0, 0, 0));
      cmp("in_reset_default", ad, mk(0, 0, 0, 1, 1, 0, 0, 0));
      #1 reset_n = 1'b1;
      foreach (tbl[i]) begin
         while (m < tbl[i].m) @(negedge vga_clk);
         cmp($sformatf("vec%0d", i), tbl[i].sel == 0 ? a1 : tbl[i].sel == 1 ? a0 : ad, tbl[i].e);
      end
      for (int i = 0; i < 6; i++) begin
         repeat ($urandom_range(1, 400)) @(posedge vga_clk);
         #($urandom_range(1, 4)) reset_n = 1'b0;
         #1;
         cmp("async_reset_small", a1, mk(0, 0, 0, 1, 1, 0, 0, 0));
         cmp("async_reset_default", ad, mk(0, 0, 0, 1, 1, 0, 0, 0));
         repeat ($urandom_range(1, 4)) @(posedge vga_clk);
         #($urandom_range(1, 4)) reset_n = 1'b1;
         @(posedge vga_clk);
         @(negedge vga_clk);
         cmp("first_edge_small", a1, mk(0, 0, 1, 1, 1, 1, 1, 0));
         cmp("first_edge_default", ad, mk(0, 0, 1, 1, 1, 1, 1, 0));
      end
      repeat (200) @(posedge vga_clk);
      @(negedge vga_clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
